// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: version, W1C interrupt status/enable,
// byte-strobed control registers and sampled read-only status words.
module axi_lite_reg_bank #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_RW     = 4,
  parameter int unsigned NUM_RO     = 2,
  parameter logic [31:0] CTRL_RESET = 32'h0,
  parameter logic [31:0] VERSION    = 32'h2000_0000
) (
  input  logic                   i_axi_clk,
  input  logic                   i_axi_rst,
  input  logic                   i_awvalid,
  input  logic [ADDR_WIDTH-1:0]  i_awaddr,
  output logic                   o_awready,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_wstrb,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  output logic [1:0]             o_bresp,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  input  logic [ADDR_WIDTH-1:0]  i_araddr,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [1:0]             o_rresp,
  output logic [31:0]            o_rdata,
  output logic [32*NUM_RW-1:0]   o_ctrl,
  output logic [NUM_RW-1:0]      o_ctrl_wr_stb,
  input  logic [32*NUM_RO-1:0]   i_status,
  input  logic [31:0]            i_int_set,
  output logic                   o_irq
);

  localparam int unsigned CTRL_LO = 3;
  localparam int unsigned STAT_LO = 3 + NUM_RW;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  wstate_e               wst_q, wst_d;
  rstate_e               rst_q, rst_d;
  logic                  aw_have_q, aw_have_d;
  logic                  w_have_q, w_have_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_RW-1:0]     stb_q, stb_d;
  logic [31:0]           ctrl_q [NUM_RW];
  logic [31:0]           ctrl_d [NUM_RW];
  logic [31:0]           int_en_q, int_en_d;
  logic [31:0]           int_sts_q, int_sts_d;
  logic                  irq_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [31:0]           eff_data, eff_mask, clr, widx, ridx;
  logic [3:0]            eff_strb;
  logic                  unused_addr;

  assign unused_addr = ^{i_awaddr[1:0], i_araddr[1:0]};

  assign o_awready = (wst_q == W_IDLE) && !aw_have_q && i_axi_rst;
  assign o_wready  = (wst_q == W_IDLE) && !w_have_q && i_axi_rst;
  assign o_arready = (rst_q == R_IDLE) && i_axi_rst;
  assign aw_hs     = i_awvalid && o_awready;
  assign w_hs      = i_wvalid && o_wready;

  assign eff_addr = aw_have_q ? awaddr_q : i_awaddr;
  assign eff_data = w_have_q ? wdata_q : i_wdata;
  assign eff_strb = w_have_q ? wstrb_q : i_wstrb;
  assign eff_mask = {{8{eff_strb[3]}}, {8{eff_strb[2]}},
                     {8{eff_strb[1]}}, {8{eff_strb[0]}}};
  assign widx     = 32'(eff_addr[ADDR_WIDTH-1:2]);
  assign ridx     = 32'(i_araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    wst_d     = wst_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    stb_d     = '0;
    ctrl_d    = ctrl_q;
    int_en_d  = int_en_q;
    clr       = '0;
    unique case (wst_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = i_awaddr;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = i_wdata;
          wstrb_d  = i_wstrb;
        end
        // Commit on the edge where the later of AW/W is captured
        if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          wst_d     = W_RESP;
          bresp_d   = SLVERR;
          if (widx == 32'd1) begin
            clr     = eff_data & eff_mask;
            bresp_d = OKAY;
          end else if (widx == 32'd2) begin
            int_en_d = (int_en_q & ~eff_mask) | (eff_data & eff_mask);
            bresp_d  = OKAY;
          end
          for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (widx == CTRL_LO + k) begin
              ctrl_d[k] = (ctrl_q[k] & ~eff_mask) | (eff_data & eff_mask);
              stb_d[k]  = 1'b1;
              bresp_d   = OKAY;
            end
          end
        end
      end
      W_RESP: begin
        if (i_bready) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // A set pulse overrides a simultaneous W1C of the same bit
  assign int_sts_d = (int_sts_q & ~clr) | i_int_set;

  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rst_q)
      R_IDLE: begin
        if (i_arvalid) begin
          rst_d   = R_DATA;
          rdata_d = '0;
          rresp_d = SLVERR;
          if (ridx == 32'd0) begin
            rdata_d = VERSION;
            rresp_d = OKAY;
          end else if (ridx == 32'd1) begin
            rdata_d = int_sts_q;
            rresp_d = OKAY;
          end else if (ridx == 32'd2) begin
            rdata_d = int_en_q;
            rresp_d = OKAY;
          end
          for (int unsigned k = 0; k < NUM_RW; k++) begin
            if (ridx == CTRL_LO + k) begin
              rdata_d = ctrl_q[k];
              rresp_d = OKAY;
            end
          end
          for (int unsigned j = 0; j < NUM_RO; j++) begin
            if (ridx == STAT_LO + j) begin
              rdata_d = i_status[32*j +: 32];
              rresp_d = OKAY;
            end
          end
        end
      end
      R_DATA: begin
        if (i_rready) rst_d = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      stb_q     <= '0;
      for (int unsigned k = 0; k < NUM_RW; k++) ctrl_q[k] <= CTRL_RESET;
      int_en_q  <= '0;
      int_sts_q <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      stb_q     <= stb_d;
      ctrl_q    <= ctrl_d;
      int_en_q  <= int_en_d;
      int_sts_q <= int_sts_d;
      irq_q     <= |(int_sts_q & int_en_q);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign o_ctrl[32*g +: 32] = ctrl_q[g];
  end

  assign o_bvalid      = (wst_q == W_RESP);
  assign o_bresp       = bresp_q;
  assign o_rvalid      = (rst_q == R_DATA);
  assign o_rdata       = rdata_q;
  assign o_rresp       = rresp_q;
  assign o_ctrl_wr_stb = stb_q;
  assign o_irq         = irq_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank: stimulus queues expected
// B/R responses, a negedge monitor pops them on each handshake.
module tb_axi_lite_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_awvalid, o_awready, i_wvalid, o_wready;
  logic [15:0] i_awaddr, i_araddr;
  logic [31:0] i_wdata, i_int_set, o_rdata;
  logic [3:0]  i_wstrb;
  logic        o_bvalid, i_bready, i_arvalid, o_arready;
  logic        o_rvalid, i_rready, o_irq;
  logic [1:0]  o_bresp, o_rresp;
  logic [127:0] o_ctrl;
  logic [3:0]  o_ctrl_wr_stb;
  logic [63:0] i_status;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          stb_cnt [4];
  logic [31:0] ctrl_m [4];

  axi_lite_reg_bank dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n),
    .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .o_bresp(o_bresp), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .i_araddr(i_araddr), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_rresp(o_rresp), .o_rdata(o_rdata), .o_ctrl(o_ctrl),
    .o_ctrl_wr_stb(o_ctrl_wr_stb), .i_status(i_status),
    .i_int_set(i_int_set), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0]  eb;
    logic [33:0] er;
    if (rst_n) begin
      for (int k = 0; k < 4; k++)
        if (o_ctrl_wr_stb[k]) stb_cnt[k]++;
      if (o_bvalid && i_bready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else begin
          eb = bq.pop_front();
          chk("bresp", 32'(o_bresp), 32'(eb));
        end
      end
      if (o_rvalid && i_rready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          er = rq.pop_front();
          chk("rdata", o_rdata, er[31:0]);
          chk("rresp", 32'(o_rresp), 32'(er[33:32]));
        end
      end
    end
  end

  task automatic aw_w(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int w_lead,
                      input logic [31:0] iset);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int t = 0;
    @(posedge clk); #1;
    i_wvalid = 1'b1; i_wdata = d; i_wstrb = s; i_awaddr = a;
    i_awvalid = (w_lead == 0); i_int_set = iset;
    while (!(aw_done && w_done) && t < 20) begin
      @(negedge clk);
      aw_f = i_awvalid && o_awready;
      w_f  = i_wvalid && o_wready;
      @(posedge clk); #1;
      i_int_set = '0;
      t++;
      if (aw_f) begin aw_done = 1; i_awvalid = 1'b0; end
      if (w_f) begin w_done = 1; i_wvalid = 1'b0; end
      if (!aw_done && t >= w_lead) i_awvalid = 1'b1;
    end
    if (!(aw_done && w_done)) chk("aw_w_timeout", 32'd0, 32'd1);
    else chk("bvalid_next", 32'(o_bvalid), 32'd1);
  endtask

  task automatic b_phase(input int hold, input logic [1:0] er);
    bit done = 0;
    int t = 0;
    for (int i = 0; i < hold; i++) begin
      chk("bvalid_hold", 32'(o_bvalid), 32'd1);
      chk("bresp_hold", 32'(o_bresp), 32'(er));
      chk("ready_low", 32'({o_awready, o_wready}), 32'd0);
      @(posedge clk); #1;
    end
    i_bready = 1'b1;
    while (!done && t < 20) begin
      @(negedge clk); done = o_bvalid;
      @(posedge clk); #1; t++;
    end
    i_bready = 1'b0;
    if (!done) chk("b_timeout", 32'd0, 32'd1);
    else chk("ready_back", 32'({o_awready, o_wready}), 32'd3);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er,
                    input int w_lead, input int hold,
                    input logic [31:0] iset);
    bq.push_back(er);
    aw_w(a, d, s, w_lead, iset);
    b_phase(hold, er);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] ed,
                    input logic [1:0] er);
    bit done = 0;
    int t = 0;
    rq.push_back({er, ed});
    @(posedge clk); #1;
    i_araddr = a; i_arvalid = 1'b1; i_rready = 1'b1;
    while (!done && t < 20) begin
      @(negedge clk); done = o_arready;
      @(posedge clk); #1; t++;
    end
    i_arvalid = 1'b0;
    if (!done) chk("ar_timeout", 32'd0, 32'd1);
    done = 0; t = 0;
    while (!done && t < 20) begin
      @(negedge clk); done = o_rvalid;
      @(posedge clk); #1; t++;
    end
    i_rready = 1'b0;
    if (!done) chk("r_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_ctrl(input string nm);
    for (int k = 0; k < 4; k++) chk(nm, o_ctrl[32*k +: 32], ctrl_m[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
    i_bready = 0; i_rready = 0;
    i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_wstrb = '0;
    i_int_set = '0;
    i_status = {32'h1111_2222, 32'hCAFE_F00D};
    for (int k = 0; k < 4; k++) begin stb_cnt[k] = 0; ctrl_m[k] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", 32'(o_bvalid), 32'd0);
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_stb", 32'(o_ctrl_wr_stb), 32'd0);
    chk("rst_readies", 32'({o_awready, o_wready, o_arready}), 32'd0);
    chk_ctrl("rst_ctrl");
    rst_n = 1'b1;

    // 1: full write, same-cycle AW/W
    wr(16'h000C, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, '0);
    ctrl_m[0] = 32'hDEAD_BEEF;
    chk("t1_stb", 32'(stb_cnt[0]), 32'd1);
    rd(16'h000C, 32'hDEAD_BEEF, 2'b00);

    // 2: partial strobes, zero strobe, version
    wr(16'h000C, 32'h1234_5678, 4'h3, 2'b00, 0, 0, '0);
    ctrl_m[0] = 32'hDEAD_5678;
    rd(16'h000C, 32'hDEAD_5678, 2'b00);
    wr(16'h000C, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 0, '0);
    chk("t2_stb0", 32'(stb_cnt[0]), 32'd3);
    rd(16'h000C, 32'hDEAD_5678, 2'b00);
    rd(16'h0000, 32'h2000_0000, 2'b00);

    // 3: W leads AW by 3 cycles, B held off 4 cycles
    wr(16'h0010, 32'h0000_00A5, 4'hF, 2'b00, 3, 4, '0);
    ctrl_m[1] = 32'h0000_00A5;
    chk("t3_stb1", 32'(stb_cnt[1]), 32'd1);
    chk_ctrl("t3_ctrl");

    // 4: error paths and status sampling
    wr(16'h0024, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, '0);
    wr(16'h0000, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, '0);
    wr(16'h001C, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, '0);
    chk_ctrl("t4_ctrl");
    chk("t4_stb_none", 32'(stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3]),
        32'd4);
    rd(16'h0024, 32'h0, 2'b10);
    rd(16'h0000, 32'h2000_0000, 2'b00);
    rd(16'h001C, 32'hCAFE_F00D, 2'b00);
    rd(16'h0020, 32'h1111_2222, 2'b00);

    // 5: interrupts
    wr(16'h0008, 32'h0000_0008, 4'hF, 2'b00, 0, 0, '0);
    @(posedge clk); #1; i_int_set = 32'h8;
    @(posedge clk); #1; i_int_set = '0;
    chk("t5_irq_lat1", 32'(o_irq), 32'd0);
    @(posedge clk); #1;
    chk("t5_irq_lat2", 32'(o_irq), 32'd1);
    rd(16'h0004, 32'h8, 2'b00);
    rd(16'h0004, 32'h8, 2'b00);
    rd(16'h0008, 32'h8, 2'b00);
    wr(16'h0004, 32'h8, 4'hF, 2'b00, 0, 0, 32'h8);
    rd(16'h0004, 32'h8, 2'b00);
    chk("t5_irq_kept", 32'(o_irq), 32'd1);
    wr(16'h0004, 32'h8, 4'hF, 2'b00, 0, 0, '0);
    chk("t5_irq_clr", 32'(o_irq), 32'd0);
    rd(16'h0004, 32'h0, 2'b00);

    // 6: reset with a write response pending
    @(posedge clk); #1; i_int_set = 32'h8;
    @(posedge clk); #1; i_int_set = '0;
    @(posedge clk); #1;
    chk("t6_irq_pre", 32'(o_irq), 32'd1);
    bq.push_back(2'b00);
    aw_w(16'h000C, 32'h5, 4'hF, 0, '0);
    chk("t6_ctrl0_pre", o_ctrl[31:0], 32'h5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    bq.delete();
    for (int k = 0; k < 4; k++) ctrl_m[k] = '0;
    chk("t6_bvalid", 32'(o_bvalid), 32'd0);
    chk("t6_irq", 32'(o_irq), 32'd0);
    chk_ctrl("t6_ctrl");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(16'h000C, 32'h77, 4'hF, 2'b00, 0, 0, '0);
    rd(16'h000C, 32'h77, 2'b00);
    rd(16'h0008, 32'h0, 2'b00);
    rd(16'h0004, 32'h0, 2'b00);

    repeat (2) @(posedge clk);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
Self-contained, parametrised AXI4-Lite slave register bank. It replaces the fixed control/version template with a generic register file containing:
- NUM_RW byte-strobed control registers
- NUM_RO read-only status registers
- a sticky write-1-to-clear interrupt status register with an enable mask and an interrupt output

The read and write channels run as independent state machines. It sits between the AXI interconnect and user logic in each core.

Parameters:
ADDR_WIDTH, 16, AXI address width; word index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored
NUM_RW, 4, number of 32-bit read/write control registers (1..16)
NUM_RO, 2, number of 32-bit read-only status registers (1..16)
CTRL_RESET, 0, 32-bit reset value applied to every control register
VERSION, 32'h2000_0000, constant returned at index 0 (major 2 in [31:28], minor in [27:20], revision in [19:16])

Ports:
i_axi_clk  in  1  clock
i_axi_rst  in  1  synchronous active-low reset
i_awvalid  in  1  write address valid
i_awaddr  in  ADDR_WIDTH  write address
o_awready  out  1  write address ready
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
i_wdata  in  32  write data
i_wstrb  in  4  byte strobes
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
o_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
i_araddr  in  ADDR_WIDTH  read address
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_rresp  out  2  read response
o_rdata  out  32  read data
o_ctrl  out  32*NUM_RW  flat control registers; reg k at bits [32k+31:32k]
o_ctrl_wr_stb  out  NUM_RW  one-cycle pulse when control reg k is written
i_status  in  32*NUM_RO  flat status inputs, sampled at the read-address handshake
i_int_set  in  32  per-bit interrupt set pulses
o_irq  out  1  registered OR of (INT_STATUS & INT_ENABLE)

Behaviour:
Address map (word index):
- 0: VERSION (RO)
- 1: INT_STATUS (W1C)
- 2: INT_ENABLE (RW)
- 3..3+NUM_RW-1: CTRL
- next NUM_RO indices: STATUS (RO)
- all higher indices: invalid

Reset (i_axi_rst==0 at a clock edge):
- All outputs 0, except o_ctrl = CTRL_RESET per register.
- INT_STATUS = 0, INT_ENABLE = 0.
- Both FSMs return to IDLE.
- Any in-flight transaction is dropped and no response is issued.

Write FSM (W_IDLE, W_RESP):
- In W_IDLE, o_awready=1 until AW is captured and o_wready=1 until W is captured.
- AW and W may arrive in either order or in the same cycle; each is latched independently.
- On the cycle after both are captured:
  - the register update takes effect
  - o_bvalid=1, o_bresp is valid
  - o_ctrl_wr_stb[k] pulses for exactly one cycle if CTRL k was targeted
  - the FSM enters W_RESP
- In W_RESP, o_awready=o_wready=0. o_bvalid and o_bresp are held until i_bready; on handshake the FSM returns to W_IDLE, with readies high the following cycle.

Write semantics:
- CTRL and INT_ENABLE: byte lane n is updated only if i_wstrb[n]; wstrb=0 gives OKAY with no change (strobe still pulses).
- INT_STATUS: bits where (wdata & strobed-lane mask) = 1 are cleared; OKAY.
- VERSION, STATUS or an invalid index: no state change, SLVERR.

Read FSM (R_IDLE, R_DATA):
- In R_IDLE, o_arready=1. On AR handshake the data (including i_status) is sampled and the FSM enters R_DATA; o_rvalid=1 on the next cycle.
- o_rdata and o_rresp are held stable until i_rready, then the FSM returns to R_IDLE.
- Invalid index: o_rdata=0, SLVERR. Reading INT_STATUS does not clear it.
- The read and write FSMs operate concurrently. A read of a register being written in the same cycle returns the pre-write value.

Interrupts:
- INT_STATUS[b] is set the cycle after i_int_set[b]=1.
- If a set and a W1C clear of the same bit occur in the same cycle, set wins.
- o_irq is registered, so it asserts 2 cycles after the i_int_set pulse when enabled.

Test Plan:
1. Write CTRL0 (addr 0x0C) with 0xDEADBEEF, wstrb=0xF, AW and W in the same cycle → bvalid the next cycle, bresp=00, o_ctrl_wr_stb[0] pulses once; read 0x0C → rdata=0xDEADBEEF, rresp=00.
2. Write 0x12345678 to 0x0C with wstrb=0x3 → readback 0xDEAD5678. Read 0x00 → 0x20000000.
3. W presented 3 cycles before AW, with i_bready low for 4 cycles → bvalid held and bresp stable, then single stb pulse; awready/wready re-assert the cycle after the B handshake.
4. Write 0xFFFFFFFF to an invalid index and to VERSION → bresp=10, no register change. Read an invalid index → rdata=0, rresp=10. With i_status[31:0]=0xCAFEF00D, read STATUS0 (addr (3+NUM_RW)<<2) → 0xCAFEF00D.
5. INT_ENABLE=0x8 and i_int_set=0x8 for 1 cycle → INT_STATUS=0x8, o_irq=1 two cycles later. W1C 0x8 together with a simultaneous i_int_set=0x8 → bit stays 1; W1C alone → bit 0, o_irq=0 one cycle later.
6. Assert reset while bvalid is pending and CTRL0=0x5 → o_bvalid=0, o_ctrl=CTRL_RESET, o_irq=0; after release, a new write completes normally.
